// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: opcode values, instruction
// field positions, FSM state encoding and the jump-offset sign extension.
package fetch_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_J   = 2'b11;

  localparam int OP_HI  = 7;
  localparam int OP_LO  = 6;
  localparam int RS_HI  = 5;
  localparam int RS_LO  = 4;
  localparam int RT_HI  = 3;
  localparam int RT_LO  = 2;
  localparam int IMM_HI = 1;
  localparam int IMM_LO = 0;

  localparam int INSTR_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

  // Two's-complement widening of the 2-bit jump immediate: 00->0, 01->+1, 10->-2, 11->-1.
  function automatic logic [INSTR_W-1:0] sext2(input logic [1:0] v);
    return {{(INSTR_W-2){v[1]}}, v};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_rom.sv
// Program storage for the fetch unit: 2**ADDR_W bytes, written on the clock edge
// and read combinationally so a same-edge write never disturbs the word being fetched.
module instruction_rom #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [7:0] mem [DEPTH];

  // Contents deliberately survive reset so a program loaded once can be re-run.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: program counter, jump pre-decode and registered instruction output,
// producing one instruction per unstalled cycle with no bubble after a taken jump.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = 4,
  parameter int RESET_PC = 0
) (
  input  logic              oscillator,
  input  logic              reset,
  input  logic              run,
  input  logic              stall,
  input  logic              pc_clear,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [7:0]        prog_data,
  output logic [7:0]        instruction,
  output logic [7:0]        instruction_address,
  output logic              valid,
  output logic [7:0]        fetch_count
);

  localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        instr_q, instr_d;
  logic [7:0]        addr_q, addr_d;
  logic              valid_q, valid_d;
  logic [7:0]        count_q, count_d;

  logic [7:0]        rom_rdata;
  logic              rom_we;
  logic              is_jump;
  logic [ADDR_W-1:0] jump_offset;
  logic [ADDR_W-1:0] next_pc;
  logic              do_fetch;

  assign rom_we = prog_we && (state_q == ST_IDLE);

  instruction_rom #(
    .ADDR_W (ADDR_W)
  ) u_rom (
    .clk   (oscillator),
    .we    (rom_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc_q),
    .rdata (rom_rdata)
  );

  // Resolving the jump target from the word being fetched lets the next edge
  // already fetch from the target, so jumps cost no extra cycle.
  always_comb begin
    is_jump     = (rom_rdata[OP_HI:OP_LO] == OP_J);
    jump_offset = '0;
    if (is_jump) begin
      jump_offset = ADDR_W'(sext2(rom_rdata[IMM_HI:IMM_LO]));
    end
    next_pc = pc_q + PC_ONE + jump_offset;
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    addr_d   = addr_q;
    valid_d  = valid_q;
    count_d  = count_q;
    do_fetch = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        if (run && !stall) begin
          do_fetch = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!run) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end else if (!stall) begin
          do_fetch = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase

    if (do_fetch) begin
      instr_d = rom_rdata;
      addr_d  = 8'(pc_q);
      valid_d = 1'b1;
      pc_d    = next_pc;
      if (count_q != 8'hFF) begin
        count_d = count_q + 8'd1;
      end
    end

    // A clear issued together with a fetch still lands; the fetch has already used the old PC.
    if ((state_q == ST_IDLE) && pc_clear) begin
      pc_d = PC_INIT;
    end
  end

  always_ff @(posedge oscillator or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pc_q    <= PC_INIT;
      instr_q <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign instruction         = instr_q;
  assign instruction_address = addr_q;
  assign valid               = valid_q;
  assign fetch_count         = count_q;

endmodule
